peri_bus_xbar: RTL

- Parametrised single-master peripheral interconnect between the core's peripheral port and NUM_PERI slaves (UART, CAN, LCD, PKT, ...).
- Decodes each request against a per-slave base-address table and issues a one-cycle strobe to exactly one slave.
- Holds address, data and strobe stable until that slave responds, then returns the read data.
- Adds decode-miss and timeout error responses, byte strobes to every slave, and an explicit one-outstanding transaction FSM.

---
 rtl/peri_bus_pkg.sv | 24 ++
 rtl/peri_addr_decoder.sv | 41 ++++
 rtl/peri_bus_xbar.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/peri_bus_pkg.sv
`default_nettype none
// ============================================================================
// peri_bus_pkg : shared types and defaults for the peripheral crossbar
// Revision 1.0
// ============================================================================
package peri_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int c_UART = 0;
   localparam int c_CAN  = 1;
   localparam int c_LCD  = 2;
   localparam int c_PKT  = 3;

   localparam int          c_NUM_PERI_DEF   = 4;
   localparam logic [63:0] c_BASE_ADDRS_DEF = {16'h1004, 16'h1003, 16'h1002, 16'h1001};
   localparam logic [31:0] c_ERR_RDATA_DEF  = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/peri_addr_decoder.sv
`default_nettype none
// ============================================================================
// peri_addr_decoder : base-address match, lowest index wins on overlap
// Revision 1.0
// ============================================================================
module peri_addr_decoder
#(
   parameter int                          NUM_PERI   = 4,
   parameter int                          DEC_W      = 16,
   parameter int                          IDX_W      = 2,
   parameter logic [NUM_PERI*DEC_W-1:0]   BASE_ADDRS = '0
) (
   input  logic [DEC_W-1:0]    i_field,
   output logic [NUM_PERI-1:0] o_onehot,
   output logic                o_hit,
   output logic [IDX_W-1:0]    o_idx
);

   logic [NUM_PERI-1:0] w_match;

   for (genvar k = 0; k < NUM_PERI; k++) begin : g_match
      assign w_match[k] = (i_field == BASE_ADDRS[k*DEC_W +: DEC_W]);
   end

   assign o_hit = |w_match;

   // Scanning downward lets the lowest matching index overwrite any higher one.
   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      for (int k = NUM_PERI - 1; k >= 0; k--) begin
         if (w_match[k]) begin
            o_onehot    = '0;
            o_onehot[k] = 1'b1;
            o_idx       = IDX_W'(k);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/peri_bus_xbar.sv
`default_nettype none
// ============================================================================
// peri_bus_xbar : single-master, one-outstanding peripheral interconnect
// Revision 1.0
// ============================================================================
module peri_bus_xbar
   import peri_bus_pkg::*;
#(
   parameter int                                    NUM_PERI    = c_NUM_PERI_DEF,
   parameter int                                    DEC_HI      = 31,
   parameter int                                    DEC_LO      = 16,
   parameter logic [NUM_PERI*(DEC_HI-DEC_LO+1)-1:0] BASE_ADDRS  = c_BASE_ADDRS_DEF,
   parameter int                                    TIMEOUT_CYC = 255,
   parameter logic [31:0]                           ERR_RDATA   = c_ERR_RDATA_DEF
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     peri_rden_i,
   input  logic                     peri_wren_i,
   input  logic [31:0]              peri_addr_i,
   input  logic [31:0]              peri_wdata_i,
   input  logic [3:0]               peri_wstrb_i,
   output logic                     peri_ready_o,
   output logic [31:0]              peri_rdata_o,
   output logic                     peri_err_o,
   output logic [NUM_PERI*32-1:0]   addr_32b_o,
   output logic [NUM_PERI-1:0]      wren_o,
   output logic [NUM_PERI-1:0]      rden_o,
   output logic [NUM_PERI*32-1:0]   din_32b_o,
   output logic [NUM_PERI*4-1:0]    wstrb_o,
   input  logic [NUM_PERI-1:0]      dout_32b_valid_i,
   input  logic [NUM_PERI*32-1:0]   dout_32b_i
);

   localparam int DEC_W = DEC_HI - DEC_LO + 1;
   localparam int IDX_W = (NUM_PERI > 1) ? $clog2(NUM_PERI) : 1;
   localparam int TMR_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [TMR_W-1:0] c_TMR_LAST = (TIMEOUT_CYC > 0) ? TMR_W'(TIMEOUT_CYC - 1) : '0;

   state_t                  r_state, w_state_nxt;
   logic [IDX_W-1:0]        r_sel, w_sel_nxt;
   logic [TMR_W-1:0]        r_timer, w_timer_nxt;
   logic                    r_ready, w_ready_nxt;
   logic [31:0]             r_rdata, w_rdata_nxt;
   logic                    r_err, w_err_nxt;
   logic [NUM_PERI-1:0]     r_rden, w_rden_nxt;
   logic [NUM_PERI-1:0]     r_wren, w_wren_nxt;
   logic [NUM_PERI*32-1:0]  r_addr, w_addr_nxt;
   logic [NUM_PERI*32-1:0]  r_din, w_din_nxt;
   logic [NUM_PERI*4-1:0]   r_wstrb, w_wstrb_nxt;

   logic [NUM_PERI-1:0]     w_dec_onehot;
   logic                    w_dec_hit;
   logic [IDX_W-1:0]        w_dec_idx;
   logic                    w_req, w_issue, w_accept, w_timeout;
   logic [31:0]             w_slave_rdata;

   peri_addr_decoder #(
      .NUM_PERI   (NUM_PERI),
      .DEC_W      (DEC_W),
      .IDX_W      (IDX_W),
      .BASE_ADDRS (BASE_ADDRS)
   ) u_dec (
      .i_field  (peri_addr_i[DEC_HI:DEC_LO]),
      .o_onehot (w_dec_onehot),
      .o_hit    (w_dec_hit),
      .o_idx    (w_dec_idx)
   );

   // Simultaneous read and write is malformed and is answered like a miss.
   assign w_req         = peri_rden_i | peri_wren_i;
   assign w_issue       = w_req && !(peri_rden_i && peri_wren_i) && w_dec_hit;
   assign w_accept      = dout_32b_valid_i[r_sel];
   assign w_slave_rdata = dout_32b_i[32*r_sel +: 32];
   assign w_timeout     = (TIMEOUT_CYC != 0) && (r_timer == c_TMR_LAST);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_req) w_state_nxt = w_issue ? ST_WAIT : ST_RESP;
         ST_WAIT: if (w_accept || w_timeout) w_state_nxt = ST_RESP;
         ST_RESP: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_sel_nxt   = r_sel;
      w_timer_nxt = r_timer;
      w_ready_nxt = 1'b0;
      w_rdata_nxt = r_rdata;
      w_err_nxt   = r_err;
      w_rden_nxt  = '0;
      w_wren_nxt  = '0;
      w_addr_nxt  = r_addr;
      w_din_nxt   = r_din;
      w_wstrb_nxt = r_wstrb;
      case (r_state)
         ST_IDLE: begin
            if (w_issue) begin
               w_rden_nxt  = w_dec_onehot & {NUM_PERI{peri_rden_i}};
               w_wren_nxt  = w_dec_onehot & {NUM_PERI{peri_wren_i}};
               w_addr_nxt  = '0;
               w_din_nxt   = '0;
               w_wstrb_nxt = '0;
               w_addr_nxt[32*w_dec_idx +: 32] = peri_addr_i;
               w_din_nxt[32*w_dec_idx +: 32]  = peri_wdata_i;
               w_wstrb_nxt[4*w_dec_idx +: 4]  = peri_wstrb_i;
               w_sel_nxt   = w_dec_idx;
               w_timer_nxt = '0;
            end else if (w_req) begin
               w_ready_nxt = 1'b1;
               w_rdata_nxt = ERR_RDATA;
               w_err_nxt   = 1'b1;
            end
         end
         ST_WAIT: begin
            // A valid on the last allowed cycle takes priority over the timeout.
            if (w_accept || w_timeout) begin
               w_ready_nxt = 1'b1;
               w_rdata_nxt = w_accept ? w_slave_rdata : ERR_RDATA;
               w_err_nxt   = !w_accept;
               w_addr_nxt  = '0;
               w_din_nxt   = '0;
               w_wstrb_nxt = '0;
            end else if (r_timer != '1) begin
               w_timer_nxt = r_timer + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sel   <= '0;
         r_timer <= '0;
         r_ready <= 1'b0;
         r_rdata <= '0;
         r_err   <= 1'b0;
         r_rden  <= '0;
         r_wren  <= '0;
         r_addr  <= '0;
         r_din   <= '0;
         r_wstrb <= '0;
      end else begin
         r_sel   <= w_sel_nxt;
         r_timer <= w_timer_nxt;
         r_ready <= w_ready_nxt;
         r_rdata <= w_rdata_nxt;
         r_err   <= w_err_nxt;
         r_rden  <= w_rden_nxt;
         r_wren  <= w_wren_nxt;
         r_addr  <= w_addr_nxt;
         r_din   <= w_din_nxt;
         r_wstrb <= w_wstrb_nxt;
      end
   end

   assign peri_ready_o = r_ready;
   assign peri_rdata_o = r_rdata;
   assign peri_err_o   = r_err;
   assign rden_o       = r_rden;
   assign wren_o       = r_wren;
   assign addr_32b_o   = r_addr;
   assign din_32b_o    = r_din;
   assign wstrb_o      = r_wstrb;

endmodule
`default_nettype wire
